// File: rtl/music_pkg.sv
// Shared note codes, player state encoding and the half-period table builder for note_player.
package music_pkg;

  localparam logic [3:0] NoteRest = 4'd0;
  localparam logic [3:0] NoteC4   = 4'd1;
  localparam logic [3:0] NoteCs4  = 4'd2;
  localparam logic [3:0] NoteD4   = 4'd3;
  localparam logic [3:0] NoteDs4  = 4'd4;
  localparam logic [3:0] NoteE4   = 4'd5;
  localparam logic [3:0] NoteF4   = 4'd6;
  localparam logic [3:0] NoteFs4  = 4'd7;
  localparam logic [3:0] NoteG4   = 4'd8;
  localparam logic [3:0] NoteGs4  = 4'd9;
  localparam logic [3:0] NoteA4   = 4'd10;
  localparam logic [3:0] NoteAs4  = 4'd11;
  localparam logic [3:0] NoteB4   = 4'd12;

  typedef enum logic {
    StIdle = 1'b0,
    StPlay = 1'b1
  } state_e;

  // Half-periods in cycles at a 100 MHz reference; zero marks a rest code.
  localparam int unsigned Hp100M [16] = '{
    0, 191110, 180388, 170265, 160704, 151685, 143170,
    135139, 127551, 120395, 113636, 107259, 101239, 0, 0, 0
  };

  typedef logic [15:0][31:0] hp_table_t;

  // Rescales the reference table to clk_hz with round-to-nearest; evaluated at elaboration.
  function automatic hp_table_t build_hp_table(input int unsigned clk_hz);
    hp_table_t       t;
    longint unsigned scaled;
    t = '0;
    for (int unsigned n = 0; n < 16; n++) begin
      scaled = (64'(Hp100M[n[3:0]]) * 64'(clk_hz) + 64'd50_000_000) / 64'd100_000_000;
      t[n[3:0]] = 32'(scaled);
    end
    return t;
  endfunction

endpackage

// File: rtl/note_player_if.sv
// Note request / playback handshake between the controller and note_player.
interface note_player_if;
  logic       START;
  logic [3:0] TONE;
  logic [3:0] DURATION;
  logic       P;
  logic       BUSY;
  logic       DONE;

  modport master (
    output START, TONE, DURATION,
    input  P, BUSY, DONE
  );

  modport slave (
    input  START, TONE, DURATION,
    output P, BUSY, DONE
  );
endinterface

// File: rtl/note_divider.sv
// Half-period counter and square-wave flop; counts only while playing a pitched note.
module note_divider
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned HP_W   = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       play,
  input  logic [3:0] tone,
  output logic       p
);

  localparam hp_table_t HpTable = build_hp_table(CLK_HZ);

  logic [HP_W-1:0] hp;
  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            p_q, p_d;

  assign hp = HpTable[tone][HP_W-1:0];

  always_comb begin
    cnt_d = cnt_q;
    p_d   = p_q;
    if (clr) begin
      cnt_d = '0;
      p_d   = 1'b0;
    end else if (play && (hp != '0)) begin
      if (cnt_q == hp - HP_W'(1)) begin
        cnt_d = '0;
        p_d   = ~p_q;
      end else begin
        cnt_d = cnt_q + HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      p_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/note_player.sv
// Timed note player: plays one latched note for DURATION units, then pulses DONE.
module note_player
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned UNIT_CYCLES = 6_250_000,
  parameter int unsigned HP_W        = 18,
  parameter int unsigned UNIT_W      = 23
) (
  input  logic         CLK,
  input  logic         RST,
  note_player_if.slave bus
);

  state_e            state_q, state_d;
  logic [3:0]        tone_q, tone_d;
  logic [3:0]        rem_q, rem_d;
  logic [UNIT_W-1:0] unit_q, unit_d;
  logic              done_q, done_d;
  logic              note_end;
  logic              unit_wrap;

  assign unit_wrap = (unit_q == UNIT_W'(UNIT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    tone_d   = tone_q;
    rem_d    = rem_q;
    unit_d   = unit_q;
    done_d   = 1'b0;
    note_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          if (bus.DURATION != 4'd0) begin
            tone_d  = bus.TONE;
            rem_d   = bus.DURATION;
            unit_d  = '0;
            state_d = StPlay;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StPlay: begin
        if (unit_wrap) begin
          unit_d = '0;
          if (rem_q == 4'd1) begin
            note_end = 1'b1;
            rem_d    = 4'd0;
            done_d   = 1'b1;
            state_d  = StIdle;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end else begin
          unit_d = unit_q + UNIT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      tone_q  <= 4'd0;
      rem_q   <= 4'd0;
      unit_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      rem_q   <= rem_d;
      unit_q  <= unit_d;
      done_q  <= done_d;
    end
  end

  // Clearing on the final edge drops P together with BUSY.
  note_divider #(
    .CLK_HZ (CLK_HZ),
    .HP_W   (HP_W)
  ) u_divider (
    .clk  (CLK),
    .rst  (RST),
    .clr  ((state_q == StIdle) || note_end),
    .play (state_q == StPlay),
    .tone (tone_q),
    .p    (bus.P)
  );

  assign bus.BUSY = (state_q == StPlay);
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player with a scaled clock (1 MHz table) and 1000-cycle units.
module tb_note_player;

  localparam int unsigned Unit = 1000;

  logic clk = 1'b0;
  logic rst;

  note_player_if bus ();

  note_player #(
    .CLK_HZ      (1_000_000),
    .UNIT_CYCLES (Unit),
    .HP_W        (18),
    .UNIT_W      (23)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Half-periods at 1 MHz: round(HP_100MHz / 100).
  int hp_exp [16] = '{0, 1911, 1804, 1703, 1607, 1517, 1432, 1351,
                      1276, 1204, 1136, 1073, 1012, 0, 0, 0};

  typedef struct {
    int len;
    int first;
    int period;
  } exp_t;

  exp_t exp_q [$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_done  = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic exp_t mk_exp(input logic [3:0] tone, input logic [3:0] dur);
    exp_t e;
    int   hp;
    hp       = hp_exp[tone];
    e.len    = int'(dur) * int'(Unit);
    e.first  = (hp != 0 && hp < e.len) ? hp : 0;
    e.period = (hp != 0 && 2 * hp < e.len) ? hp : 0;
    return e;
  endfunction

  task automatic issue(input logic [3:0] tone, input logic [3:0] dur, input bit expect_done);
    bus.TONE     = tone;
    bus.DURATION = dur;
    bus.START    = 1'b1;
    if (expect_done) exp_q.push_back(mk_exp(tone, dur));
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!bus.DONE && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"wait_", name}, int'(bus.DONE), 1);
  endtask

  // Monitor: measures each note from BUSY rise and scores it on DONE.
  initial begin : monitor
    int   busy_len = 0;
    int   first_t  = 0;
    int   second_t = 0;
    bit   p_prev = 1'b0, busy_prev = 1'b0, done_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_len = 0; first_t = 0; second_t = 0;
        p_prev = 1'b0; busy_prev = 1'b0; done_prev = 1'b0;
      end else begin
        if (bus.BUSY) begin
          if (!busy_prev) begin
            busy_len = 0; first_t = 0; second_t = 0;
          end
          if (bus.P != p_prev) begin
            if (first_t == 0) first_t = busy_len;
            else if (second_t == 0) second_t = busy_len;
          end
          busy_len++;
        end
        if (bus.DONE) begin
          check("done_width", int'(done_prev), 0);
          check("done_busy_low", int'(bus.BUSY), 0);
          check("done_p_low", int'(bus.P), 0);
          check("done_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy_len", busy_len, e.len);
            check("first_toggle", first_t, e.first);
            check("half_period", (second_t != 0) ? second_t - first_t : 0, e.period);
          end
          n_done++;
          busy_len = 0; first_t = 0; second_t = 0;
        end
        p_prev    = bus.P;
        busy_prev = bus.BUSY;
        done_prev = bus.DONE;
      end
    end
  end

  initial begin
    rst          = 1'b1;
    bus.START    = 1'b0;
    bus.TONE     = 4'd0;
    bus.DURATION = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_p", int'(bus.P), 0);
    check("reset_busy", int'(bus.BUSY), 0);
    check("reset_done", int'(bus.DONE), 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-note: no DONE may follow.
    issue(4'd10, 4'd3, 1'b0);
    repeat (1498) @(negedge clk);
    check("midnote_busy", int'(bus.BUSY), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_p", int'(bus.P), 0);
    check("rst_mid_busy", int'(bus.BUSY), 0);
    check("rst_mid_done", int'(bus.DONE), 0);
    rst = 1'b0;
    repeat (3200) @(negedge clk);
    check("no_done_after_rst", n_done, 0);

    // A4 for two units.
    issue(4'd10, 4'd2, 1'b1);
    wait_done(2100, "a4");
    repeat (3) @(negedge clk);

    // Rests.
    issue(4'd0, 4'd4, 1'b1);
    wait_done(4100, "rest0");
    repeat (3) @(negedge clk);
    issue(4'd14, 4'd1, 1'b1);
    wait_done(1100, "rest14");
    repeat (3) @(negedge clk);

    // Zero duration.
    issue(4'd10, 4'd0, 1'b1);
    wait_done(5, "zero");
    check("zero_busy", int'(bus.BUSY), 0);
    check("zero_p", int'(bus.P), 0);
    repeat (3) @(negedge clk);

    // START mid-note is ignored.
    issue(4'd1, 4'd3, 1'b1);
    repeat (500) @(negedge clk);
    bus.TONE     = 4'd12;
    bus.DURATION = 4'd1;
    bus.START    = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    wait_done(3100, "ignored");
    repeat (3) @(negedge clk);

    // Back-to-back: START during the DONE cycle.
    issue(4'd12, 4'd2, 1'b1);
    wait_done(2100, "b2b_first");
    issue(4'd5, 4'd2, 1'b1);
    check("b2b_busy", int'(bus.BUSY), 1);
    wait_done(2100, "b2b_second");
    repeat (3) @(negedge clk);

    // Table sweep: two toggles per tone.
    for (int t = 1; t <= 12; t++) begin
      issue(4'(t), 4'd5, 1'b1);
      wait_done(5100, "sweep");
      @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("done_count", n_done, 19);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
